usb_bus_bridge: RTL and testbench

Downstream stage of the USB PC command block: accepts its single-word bus requests (write data or read address), queues them in a small FIFO, and replays them one at a time onto the memory bus port. Completions return to the USB side in order, as a one-cycle ack with read data. Requests to disabled banks complete locally, and a per-transaction watchdog keeps a dead bank from hanging the link.

---
 rtl/usb_bus_bridge_pkg.sv | 20 ++
 rtl/usb_bus_bridge_if.sv | 45 ++++
 rtl/usb_bus_bridge_fifo.sv | 62 ++++++
 rtl/usb_bus_bridge.sv | 128 ++++++++++++
 tb/tb_usb_bus_bridge.sv | 465 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/usb_bus_bridge_pkg.sv
// usb_bus_bridge shared types.
// FSM states, bus error word and FIFO entry layout.
package usb_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    COMPLETE
  } state_e;

  localparam logic [31:0] BUS_ERROR = 32'hFFFF_FFFF;

  typedef struct packed {
    logic        write;
    logic [3:0]  bank;
    logic [23:0] addr;
    logic [31:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/usb_bus_bridge_if.sv
// usb_bus_bridge bus bundle.
// Upstream request/ack and memory port signals.
interface usb_bus_bridge_if;

  logic        i_request;
  logic        i_write;
  logic [3:0]  i_bank;
  logic [25:0] i_address;
  logic [31:0] i_data;
  logic        o_busy;
  logic        o_ack;
  logic [31:0] o_data;
  logic        o_mem_request;
  logic        o_mem_write;
  logic [3:0]  o_mem_bank;
  logic [25:0] o_mem_address;
  logic [31:0] o_mem_data;
  logic        i_mem_ack;
  logic [31:0] i_mem_data;
  logic        o_timeout;
  logic        i_timeout_clear;

  modport slave (
    input  i_request, i_write, i_bank,
    input  i_address, i_data,
    input  i_mem_ack, i_mem_data,
    input  i_timeout_clear,
    output o_busy, o_ack, o_data,
    output o_mem_request, o_mem_write,
    output o_mem_bank, o_mem_address,
    output o_mem_data, o_timeout
  );

  modport master (
    output i_request, i_write, i_bank,
    output i_address, i_data,
    output i_mem_ack, i_mem_data,
    output i_timeout_clear,
    input  o_busy, o_ack, o_data,
    input  o_mem_request, o_mem_write,
    input  o_mem_bank, o_mem_address,
    input  o_mem_data, o_timeout
  );

endinterface

// File: rtl/usb_bus_bridge_fifo.sv
// usb_bus_fifo: request queue for the bridge.
// Wrap-around pointers plus occupancy count.
module usb_bus_fifo
  import usb_bus_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_push,
  input  fifo_entry_t i_data,
  input  logic        i_pop,
  output fifo_entry_t o_data,
  output logic        o_empty,
  output logic        o_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fifo_entry_t    mem_q [DEPTH];
  logic [AW-1:0]  wr_q, wr_d;
  logic [AW-1:0]  rd_q, rd_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           push, pop;

  assign o_empty = (cnt_q == '0);
  assign o_full  = (cnt_q == CW'(DEPTH));
  assign push    = i_push && !o_full;
  assign pop     = i_pop && !o_empty;
  assign o_data  = mem_q[rd_q];

  // Next pointers and count; push+pop leaves count alone.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) wr_d = wr_q + 1'b1;
    if (pop)  rd_d = rd_q + 1'b1;
    if (push && !pop) cnt_d = cnt_q + 1'b1;
    if (pop && !push) cnt_d = cnt_q - 1'b1;
  end

  // Storage needs no reset; only pointers define validity.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_q] <= i_data;
  end

  // Pointer and count registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/usb_bus_bridge.sv
// usb_bus_bridge: queues USB bus requests and replays
// them onto the memory port with in-order completions.
module usb_bus_bridge
  import usb_bus_pkg::*;
#(
  parameter int          DEPTH       = 4,
  parameter logic [15:0] BANK_ENABLE = 16'h0003,
  parameter int          TIMEOUT     = 1023
) (
  input logic             i_clk,
  input logic             i_reset_n,
  usb_bus_bridge_if.slave bus
);

  localparam int WW = $clog2(TIMEOUT + 1);

  fifo_entry_t   wr_entry, head;
  logic          empty, full;
  logic          push, pop;
  logic          unused_addr;

  state_e        state_q;
  logic [WW-1:0] wd_q;
  logic          req_q;
  logic          write_q;
  logic [3:0]    bank_q;
  logic [23:0]   addr_q;
  logic [31:0]   wdata_q;
  logic          ack_q;
  logic [31:0]   rdata_q;
  logic          timeout_q;

  assign unused_addr = ^bus.i_address[1:0];

  assign wr_entry = '{
    write: bus.i_write,
    bank:  bus.i_bank,
    addr:  bus.i_address[25:2],
    data:  bus.i_data
  };

  assign push = bus.i_request && !full;
  assign pop  = (state_q == IDLE) && !empty;

  usb_bus_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_push    (push),
    .i_data    (wr_entry),
    .i_pop     (pop),
    .o_data    (head),
    .o_empty   (empty),
    .o_full    (full)
  );

  assign bus.o_busy        = full;
  assign bus.o_ack         = ack_q;
  assign bus.o_data        = rdata_q;
  assign bus.o_mem_request = req_q;
  assign bus.o_mem_write   = write_q;
  assign bus.o_mem_bank    = bank_q;
  assign bus.o_mem_address = {addr_q, 2'b00};
  assign bus.o_mem_data    = wdata_q;
  assign bus.o_timeout     = timeout_q;

  // Transaction FSM with watchdog and registered outputs.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= IDLE;
      wd_q      <= '0;
      req_q     <= 1'b0;
      write_q   <= 1'b0;
      bank_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      ack_q     <= 1'b0;
      rdata_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      if (bus.i_timeout_clear) timeout_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pop) begin
            write_q <= head.write;
            bank_q  <= head.bank;
            addr_q  <= head.addr;
            wdata_q <= head.data;
            if (BANK_ENABLE[head.bank]) begin
              state_q <= ISSUE;
              req_q   <= 1'b1;
              wd_q    <= '0;
            end else begin
              state_q <= COMPLETE;
              ack_q   <= 1'b1;
              rdata_q <= BUS_ERROR;
            end
          end
        end
        ISSUE: begin
          if (bus.i_mem_ack) begin
            state_q <= COMPLETE;
            req_q   <= 1'b0;
            ack_q   <= 1'b1;
            if (!write_q) rdata_q <= bus.i_mem_data;
          end else if (wd_q == WW'(TIMEOUT)) begin
            state_q   <= COMPLETE;
            req_q     <= 1'b0;
            ack_q     <= 1'b1;
            rdata_q   <= BUS_ERROR;
            timeout_q <= 1'b1;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        COMPLETE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_bus_bridge.sv
// tb_usb_bus_bridge: directed and randomized checks
// against a transaction-level completion model.
module tb_usb_bus_bridge;
  import usb_bus_pkg::*;

  localparam int          DEPTH = 4;
  localparam logic [15:0] BANKS = 16'h0003;
  localparam int          TMO   = 8;

  typedef struct {
    bit        write;
    bit [3:0]  bank;
    bit [25:0] addr;
    bit [31:0] data;
  } req_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  usb_bus_bridge_if bus ();

  usb_bus_bridge #(
    .DEPTH       (DEPTH),
    .BANK_ENABLE (BANKS),
    .TIMEOUT     (TMO)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_data;
  logic        exp_tmo;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_request       = 1'b0;
    bus.i_write         = 1'b0;
    bus.i_bank          = '0;
    bus.i_address       = '0;
    bus.i_data          = '0;
    bus.i_mem_ack       = 1'b0;
    bus.i_mem_data      = '0;
    bus.i_timeout_clear = 1'b0;
  endtask

  task automatic drive(input req_t r);
    bus.i_request = 1'b1;
    bus.i_write   = r.write;
    bus.i_bank    = r.bank;
    bus.i_address = r.addr;
    bus.i_data    = r.data;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({bus.o_busy, bus.o_ack, bus.o_mem_request,
         bus.o_mem_write, bus.o_timeout} !== 5'b0) begin
      errors++;
      $display("FAIL rst_flags got %b want 00000",
        {bus.o_busy, bus.o_ack, bus.o_mem_request,
         bus.o_mem_write, bus.o_timeout});
    end
    checks++;
    if (bus.o_data !== 32'h0) begin
      errors++;
      $display("FAIL rst_data got %h want 0", bus.o_data);
    end
    checks++;
    if ({bus.o_mem_bank, bus.o_mem_address, bus.o_mem_data} !== 62'h0) begin
      errors++;
      $display("FAIL rst_mem got %h want 0",
        {bus.o_mem_bank, bus.o_mem_address, bus.o_mem_data});
    end
    rst_n = 1'b1;
    tick();
    exp_data = 32'h0;
    exp_tmo  = 1'b0;
  endtask

  // Write, memory acks 2 cycles after request: o_ack at N+5.
  task automatic test_write();
    req_t r;
    r = '{write: 1'b1, bank: 4'd0, addr: 26'h0000104, data: 32'hCAFEBABE};
    drive(r);
    for (int i = 1; i <= 7; i++) begin
      tick();
      bus.i_request = 1'b0;
      checks++;
      if (bus.o_mem_request !== (i >= 2 && i <= 4)) begin
        errors++;
        $display("FAIL wr_req cyc %0d got %b", i, bus.o_mem_request);
      end
      checks++;
      if (bus.o_ack !== (i == 5)) begin
        errors++;
        $display("FAIL wr_ack cyc %0d got %b", i, bus.o_ack);
      end
      checks++;
      if (bus.o_busy !== 1'b0) begin
        errors++;
        $display("FAIL wr_busy cyc %0d got %b want 0", i, bus.o_busy);
      end
      if (i == 2) begin
        checks++;
        if ({bus.o_mem_write, bus.o_mem_bank, bus.o_mem_address,
             bus.o_mem_data} !== {1'b1, 4'd0, 26'h0000104, 32'hCAFEBABE}) begin
          errors++;
          $display("FAIL wr_fields got %b %h %h %h", bus.o_mem_write,
            bus.o_mem_bank, bus.o_mem_address, bus.o_mem_data);
        end
      end
      if (i == 5) begin
        checks++;
        if (bus.o_data !== exp_data) begin
          errors++;
          $display("FAIL wr_data got %h want %h", bus.o_data, exp_data);
        end
      end
      bus.i_mem_ack  = (i == 4);
      bus.i_mem_data = $urandom;
    end
    bus.i_mem_ack = 1'b0;
  endtask

  // Read bank 1 acked at once: o_ack one cycle after ack.
  task automatic test_read();
    req_t r;
    r = '{write: 1'b0, bank: 4'd1, addr: 26'($urandom), data: $urandom};
    drive(r);
    for (int i = 1; i <= 5; i++) begin
      tick();
      bus.i_request = 1'b0;
      checks++;
      if (bus.o_ack !== (i == 3)) begin
        errors++;
        $display("FAIL rd_ack cyc %0d got %b", i, bus.o_ack);
      end
      if (i == 2) begin
        checks++;
        if ({bus.o_mem_request, bus.o_mem_write, bus.o_mem_bank,
             bus.o_mem_address} !==
            {1'b1, 1'b0, 4'd1, r.addr[25:2], 2'b00}) begin
          errors++;
          $display("FAIL rd_fields got %b %b %h %h", bus.o_mem_request,
            bus.o_mem_write, bus.o_mem_bank, bus.o_mem_address);
        end
      end
      if (i == 3) begin
        checks++;
        if (bus.o_data !== 32'h12345678 || bus.o_mem_request !== 1'b0) begin
          errors++;
          $display("FAIL rd_data got %h req %b want 12345678 req 0",
            bus.o_data, bus.o_mem_request);
        end
        exp_data = 32'h12345678;
      end
      bus.i_mem_ack  = (i == 2);
      bus.i_mem_data = (i == 2) ? 32'h12345678 : $urandom;
    end
    bus.i_mem_ack = 1'b0;
  endtask

  // Disabled bank completes locally at N+2 with the error word.
  task automatic test_disabled();
    req_t r;
    r = '{write: 1'b0, bank: 4'd5, addr: 26'($urandom), data: $urandom};
    drive(r);
    for (int i = 1; i <= 4; i++) begin
      tick();
      bus.i_request = 1'b0;
      checks++;
      if (bus.o_mem_request !== 1'b0 || bus.o_ack !== (i == 2)) begin
        errors++;
        $display("FAIL dis_seq cyc %0d req %b ack %b", i,
          bus.o_mem_request, bus.o_ack);
      end
      if (i == 2) begin
        checks++;
        if (bus.o_data !== BUS_ERROR) begin
          errors++;
          $display("FAIL dis_data got %h want ffffffff", bus.o_data);
        end
        exp_data = BUS_ERROR;
      end
    end
  endtask

  // Ack on the very cycle the watchdog expires wins.
  task automatic test_ack_at_limit();
    req_t        r;
    logic [31:0] md;
    r  = '{write: 1'b0, bank: 4'd0, addr: 26'($urandom), data: $urandom};
    md = $urandom;
    drive(r);
    for (int i = 1; i <= TMO + 5; i++) begin
      tick();
      bus.i_request = 1'b0;
      checks++;
      if (bus.o_mem_request !== (i >= 2 && i <= TMO + 2) ||
          bus.o_ack !== (i == TMO + 3)) begin
        errors++;
        $display("FAIL lim_seq cyc %0d req %b ack %b", i,
          bus.o_mem_request, bus.o_ack);
      end
      if (i == TMO + 3) begin
        checks++;
        if (bus.o_data !== md || bus.o_timeout !== 1'b0) begin
          errors++;
          $display("FAIL lim_data got %h tmo %b want %h tmo 0",
            bus.o_data, bus.o_timeout, md);
        end
        exp_data = md;
      end
      bus.i_mem_ack  = (i == TMO + 2);
      bus.i_mem_data = md;
    end
    bus.i_mem_ack = 1'b0;
  endtask

  // Six writes to a dead memory: all abort in order.
  task automatic test_timeout_burst();
    req_t w[6];
    int   sent, acks, started, rc;
    bit   chk_full, done;
    for (int k = 0; k < 6; k++)
      w[k] = '{write: 1'b1, bank: 4'(k % 2), addr: 26'($urandom),
               data: $urandom};
    sent = 0; acks = 0; started = 0; rc = 0;
    chk_full = 0; done = 0;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      if (sent < 6) begin
        drive(w[sent]);
        if (!bus.o_busy) begin
          sent++;
          // First entry leaves the FIFO the cycle after it
          // lands, so the fifth accept is the one that fills it.
          if (sent == 5) chk_full = 1;
        end
      end else begin
        bus.i_request = 1'b0;
      end
      tick();
      if (chk_full) begin
        chk_full = 0;
        checks++;
        if (bus.o_busy !== 1'b1) begin
          errors++;
          $display("FAIL to_busy got %b want 1", bus.o_busy);
        end
      end
      if (bus.o_mem_request) begin
        if (rc == 0) begin
          checks++;
          if ({bus.o_mem_bank, bus.o_mem_address, bus.o_mem_data} !==
              {w[started].bank, w[started].addr[25:2], 2'b00,
               w[started].data}) begin
            errors++;
            $display("FAIL to_order txn %0d got %h %h %h", started,
              bus.o_mem_bank, bus.o_mem_address, bus.o_mem_data);
          end
        end
        rc++;
      end
      if (bus.o_ack) begin
        checks++;
        if (rc !== TMO + 1 || bus.o_data !== BUS_ERROR ||
            bus.o_timeout !== 1'b1) begin
          errors++;
          $display("FAIL to_abort txn %0d cycles %0d data %h tmo %b",
            started, rc, bus.o_data, bus.o_timeout);
        end
        rc = 0;
        started++;
        acks++;
        if (acks == 6) done = 1;
      end
    end
    checks++;
    if (acks !== 6) begin
      errors++;
      $display("FAIL to_count got %0d acks want 6", acks);
    end
    exp_data = BUS_ERROR;
    bus.i_timeout_clear = 1'b1;
    tick();
    bus.i_timeout_clear = 1'b0;
    checks++;
    if (bus.o_timeout !== 1'b0) begin
      errors++;
      $display("FAIL to_clear got %b want 0", bus.o_timeout);
    end
    exp_tmo = 1'b0;
  endtask

  // Random traffic against an in-order completion queue.
  task automatic test_random();
    req_t        pend[$];
    req_t        cur, hd;
    bit          have;
    int          gen, rc, lat;
    logic [31:0] md, exp;
    int          expc;
    bit          done;
    have = 0; gen = 0; rc = 0; lat = 0; md = '0; done = 0;
    for (int cyc = 0; cyc < 5000 && !done; cyc++) begin
      tick();
      if (bus.o_ack) begin
        checks++;
        if (pend.size() == 0) begin
          errors++;
          $display("FAIL rnd_spurious ack with empty model queue");
        end else begin
          hd = pend.pop_front();
          if (!BANKS[hd.bank]) begin
            exp = BUS_ERROR; expc = 0;
          end else if (lat > TMO) begin
            exp = BUS_ERROR; expc = TMO + 1; exp_tmo = 1'b1;
          end else begin
            exp = hd.write ? exp_data : md; expc = lat + 1;
          end
          exp_data = exp;
          if (bus.o_data !== exp || rc !== expc ||
              bus.o_timeout !== exp_tmo) begin
            errors++;
            $display("FAIL rnd_cpl data %h/%h cycles %0d/%0d tmo %b/%b",
              bus.o_data, exp, rc, expc, bus.o_timeout, exp_tmo);
          end
        end
        rc = 0;
      end
      if (bus.o_mem_request) begin
        if (rc == 0) begin
          lat = $urandom_range(0, 10);
          checks++;
          if (pend.size() == 0) begin
            errors++;
            $display("FAIL rnd_req memory request with empty queue");
          end else begin
            hd = pend[0];
            if ({bus.o_mem_write, bus.o_mem_bank, bus.o_mem_address} !==
                {hd.write, hd.bank, hd.addr[25:2], 2'b00} ||
                (hd.write && bus.o_mem_data !== hd.data)) begin
              errors++;
              $display("FAIL rnd_req got %b %h %h %h want %b %h %h %h",
                bus.o_mem_write, bus.o_mem_bank, bus.o_mem_address,
                bus.o_mem_data, hd.write, hd.bank, hd.addr, hd.data);
            end
          end
        end
        bus.i_mem_ack = (rc == lat);
        if (rc == lat) md = $urandom;
        bus.i_mem_data = (rc == lat) ? md : $urandom;
        rc++;
      end else begin
        bus.i_mem_ack = 1'b0;
      end
      if (!have && gen < 40 && $urandom_range(0, 2) != 0) begin
        cur = '{write: 1'($urandom), bank: 4'($urandom_range(0, 3)),
                addr: 26'($urandom), data: $urandom};
        have = 1;
        gen++;
      end
      if (have) begin
        drive(cur);
        if (!bus.o_busy) begin
          pend.push_back(cur);
          have = 0;
        end
      end else begin
        bus.i_request = 1'b0;
      end
      if (gen == 40 && !have && pend.size() == 0) done = 1;
    end
    bus.i_request = 1'b0;
    bus.i_mem_ack = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL rnd_drain %0d still pending want 0", pend.size());
    end
  endtask

  // Reset during ISSUE with three queued drops everything.
  task automatic test_reset_mid();
    req_t r;
    bit   seen;
    for (int k = 0; k < 4; k++) begin
      r = '{write: 1'b1, bank: 4'd0, addr: 26'($urandom), data: $urandom};
      drive(r);
      tick();
    end
    bus.i_request = 1'b0;
    checks++;
    if (bus.o_mem_request !== 1'b1) begin
      errors++;
      $display("FAIL mid_issue got %b want 1", bus.o_mem_request);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.o_busy, bus.o_ack, bus.o_mem_request, bus.o_mem_write,
         bus.o_timeout, bus.o_data, bus.o_mem_bank, bus.o_mem_address,
         bus.o_mem_data} !== 99'h0) begin
      errors++;
      $display("FAIL mid_rst outputs not all zero req %b data %h",
        bus.o_mem_request, bus.o_data);
    end
    tick();
    tick();
    rst_n = 1'b1;
    exp_data = 32'h0;
    exp_tmo  = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.o_ack || bus.o_mem_request) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL mid_ghost got activity after reset want none");
    end
    r = '{write: 1'b0, bank: 4'd1, addr: 26'($urandom), data: $urandom};
    drive(r);
    for (int i = 1; i <= 4; i++) begin
      tick();
      bus.i_request = 1'b0;
      checks++;
      if (bus.o_ack !== (i == 3) ||
          (i == 3 && bus.o_data !== 32'hA5A5_0F0F)) begin
        errors++;
        $display("FAIL mid_after cyc %0d ack %b data %h", i,
          bus.o_ack, bus.o_data);
      end
      bus.i_mem_ack  = (i == 2);
      bus.i_mem_data = 32'hA5A5_0F0F;
    end
    bus.i_mem_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_disabled();
    test_ack_at_limit();
    test_timeout_burst();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
